add_mop_seq: RTL and testbench
==============================

# add_mop_seq

Streaming multi-operand accumulator: accepts `lanes` operands per beat over a valid/ready handshake and accumulates an arbitrary-length frame in redundant carry-save form. On the frame's last beat it resolves the sum with a single carry-propagate addition and presents a registered result. It sits after the combinational multi-operand adder family as its sequential successor, for dot-product and checksum datapaths whose operand count is unknown at elaboration time.

## Interface
- `width`, 8: operand word width.
- `lanes`, 4: operands per beat; must be ≥ 2, since the compressor depth `lanes+2` must be ≥ 4.
- `accWidth`, 16: accumulator/result width; must be ≥ `width`.
- `cntWidth`, 8: beat-counter width.
- `speed`, 1: 0 = linear compressor and ripple final add; 1 = tree compressor and Brent-Kung final add; 2 = tree compressor and Sklansky final add.
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: block accepts a beat.
- `in_data` input `lanes*width`: operand k occupies `[k*width +: width]`.
- `in_last` input 1: beat is the final beat of the frame.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_sum` output `accWidth`: frame sum modulo 2^accWidth.
- `out_beats` output `cntWidth`: beats in the frame, saturating.

## Operation
- State registers:
  - `SR`, `CR` (`accWidth` each): carry-save accumulator.
  - `cnt` (`cntWidth`): beat counter.
  - state ∈ {ACC, RESOLVE, OUT}.
- Each operand is extended to `accWidth` (zero-extended by default; see Configuration).
- Accepted beat (`in_valid & in_ready`): a `(lanes+2, 2)` carry-save compressor of width `accWidth` reduces `lanes` operands plus `SR`, `CR` into a new `SR`/`CR`.
  - The compressor's carry output is shifted left one place; the bit shifted out of the MSB is discarded.
  - `cnt <= min(cnt+1, 2^cntWidth-1)`.
- ACC:
  - `in_ready=1`.
  - An accepted beat with `in_last=1` moves to RESOLVE.
  - An accepted beat with `in_last=0` stays in ACC.
- RESOLVE:
  - `in_ready=0`.
  - The final adder computes `SR+CR` mod 2^accWidth, registered into `out_sum`; `cnt` is registered into `out_beats`.
  - Moves to OUT unconditionally.
- OUT:
  - `out_valid=1` and `in_ready=0`.
  - `out_sum` and `out_beats` stay stable until `out_ready=1`.
  - On the handshake: `SR`, `CR`, `cnt` clear to 0, `out_valid` drops, and the state returns to ACC.
- Single-beat frames (first beat has `in_last=1`) are legal.
- No empty frames: a result is produced only after a beat with `in_last=1`.
- `in_data` and `in_last` are ignored when `in_valid=0`.
- `out_ready` is ignored outside OUT.

## Timing
- Reset asserted, asynchronously:
  - state = ACC; `SR`, `CR`, `cnt`, `out_sum`, `out_beats` = 0.
  - `out_valid=0`, `in_ready=1` (decoded from state).
- Reset mid-frame or in OUT discards the partial sum or pending result; no output is produced.
- Throughput in ACC: one beat per cycle.
- Latency: last beat accepted at edge t → `out_valid=1` from edge t+1 (RESOLVE completes at t+1, OUT visible after t+1).
  - Precisely: `out_valid` is high in the cycle following RESOLVE, 2 cycles after the last-beat cycle.
- Result accepted at edge u → `in_ready=1` in the cycle after u. Minimum frame period is beats + 2 cycles.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `out_ready` to `in_ready` or from `in_valid` to `out_valid`.
- The critical path is one compressor pass (ACC) or one final add (RESOLVE), never both in the same cycle.

## Configuration
- `ADD_MOP_SEQ_SIGNED_EN`:
  - Defined: operands are two's-complement and sign-extended to `accWidth`; `out_sum` is a two's-complement sum mod 2^accWidth.
  - Undefined: operands are unsigned and zero-extended.
- Wrap semantics are identical in both modes; there is no saturation or overflow flag.

## Test plan
- Two-beat frame, width=8, lanes=4, accWidth=16:
  - Stimulus: beat {1,2,3,4}, then beat {255,255,255,255} with `in_last`.
  - Response: `out_sum=1030`, `out_beats=2`, `out_valid` 2 cycles after the last beat.
- Wrap, accWidth=12: five beats of {255,255,255,255} → `out_sum = 5100 mod 4096 = 1004`, `out_beats=5`.
- Signed, `ADD_MOP_SEQ_SIGNED_EN`, accWidth=12: single beat {0xFF,0xFF,0xFF,0x01} with `in_last` → `out_sum=0xFFE` (−2), `out_beats=1`.
- Backpressure:
  - Stimulus: hold `out_ready=0` for 5 cycles in OUT while `in_valid=1`.
  - Response: `out_sum`/`out_beats` stable, `in_ready=0`, no beat consumed.
  - After the handshake: the next frame {1,1,1,1} with `in_last` yields 4, showing the accumulator was cleared.
- Reset mid-operation:
  - Stimulus: assert `rst_i` after 3 of 6 beats, then run frame {2,2,2,2} with `in_last`.
  - Response: `out_sum=8`, `out_beats=1`; no stale result appears.
- Counter saturation, cntWidth=2: six-beat frame → `out_beats=3`; sum still exact.

Source files
------------

// File: rtl/add_mop_seq.sv
// Streaming multi-operand accumulator: carry-save accumulation of `lanes` operands per beat,
// single carry-propagate resolve per frame. Optional macro: ADD_MOP_SEQ_SIGNED_EN (sign-extend operands).
module add_mop_seq #(
    parameter int width    = 8,
    parameter int lanes    = 4,
    parameter int accWidth = 16,
    parameter int cntWidth = 8,
    parameter int speed    = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [lanes*width-1:0]    in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [accWidth-1:0]       out_sum,
    output logic [cntWidth-1:0]       out_beats
);

    localparam int nops = lanes + 2;
    localparam int lg   = (accWidth > 1) ? $clog2(accWidth) : 1;

    typedef enum logic [1:0] {
        ACC     = 2'd0,
        RESOLVE = 2'd1,
        OUT     = 2'd2
    } state_t;

    // Number of vectors left after l levels of 3:2 reduction starting from n0 vectors.
    function automatic int lvl_cnt(input int n0, input int l);
        int n;
        n = n0;
        for (int i = 0; i < l; i++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    function automatic int tree_levels(input int n0);
        int n;
        int c;
        n = n0;
        c = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + (n % 3);
            c = c + 1;
        end
        return c;
    endfunction

    localparam int nlev = tree_levels(nops);

    function automatic logic [accWidth-1:0] ext_op(input logic [width-1:0] op);
        logic [accWidth-1:0] r;
`ifdef ADD_MOP_SEQ_SIGNED_EN
        r = {accWidth{op[width-1]}};
`else
        r = {accWidth{1'b0}};
`endif
        r[width-1:0] = op;
        return r;
    endfunction

    function automatic logic [accWidth-1:0] csa_sum(input logic [accWidth-1:0] a,
                                                    input logic [accWidth-1:0] b,
                                                    input logic [accWidth-1:0] c);
        return a ^ b ^ c;
    endfunction

    // Carry weight moves up one place; the MSB carry falls off (mod 2^accWidth).
    function automatic logic [accWidth-1:0] csa_carry(input logic [accWidth-1:0] a,
                                                      input logic [accWidth-1:0] b,
                                                      input logic [accWidth-1:0] c);
        logic [accWidth-1:0] maj;
        maj = (a & b) | (a & c) | (b & c);
        return maj << 1;
    endfunction

    state_t                 state_r;
    state_t                 state_s;
    logic [accWidth-1:0]    sr_r;
    logic [accWidth-1:0]    cr_r;
    logic [cntWidth-1:0]    cnt_r;
    logic [accWidth-1:0]    ops_s [nops];
    logic [accWidth-1:0]    comp_sum_s;
    logic [accWidth-1:0]    comp_carry_s;
    logic [accWidth-1:0]    fa_s;
    logic                   accept_s;

    // Gather accumulator pair and extended lane operands for the compressor.
    always_comb begin
        ops_s[0] = sr_r;
        ops_s[1] = cr_r;
        for (int k = 0; k < lanes; k++) begin
            ops_s[k+2] = ext_op(in_data[k*width +: width]);
        end
    end

    generate
        if (speed == 0) begin : g_lin_comp
            logic [accWidth-1:0] t_s;

            // Linear chain of 3:2 stages folding one operand at a time into the pair.
            always_comb begin
                t_s          = {accWidth{1'b0}};
                comp_sum_s   = ops_s[0];
                comp_carry_s = ops_s[1];
                for (int k = 2; k < nops; k++) begin
                    t_s          = csa_sum(comp_sum_s, comp_carry_s, ops_s[k]);
                    comp_carry_s = csa_carry(comp_sum_s, comp_carry_s, ops_s[k]);
                    comp_sum_s   = t_s;
                end
            end
        end else begin : g_tree_comp
            logic [accWidth-1:0] tv_s [nops];
            logic [accWidth-1:0] nv_s [nops];
            int                  n_s;
            int                  ng_s;
            int                  b_s;
            int                  pi_s;
            logic                grp_s;
            logic                pass_s;

            // Wallace-style levels: groups of three become sum/carry, leftovers pass through.
            always_comb begin
                tv_s   = ops_s;
                nv_s   = ops_s;
                n_s    = nops;
                ng_s   = 0;
                b_s    = 0;
                pi_s   = 0;
                grp_s  = 1'b0;
                pass_s = 1'b0;
                for (int l = 0; l < nlev; l++) begin
                    n_s  = lvl_cnt(nops, l);
                    ng_s = n_s / 3;
                    for (int k = 0; k < nops; k++) begin
                        grp_s   = (k < 2 * ng_s);
                        pass_s  = !grp_s && (k < n_s - ng_s);
                        b_s     = grp_s ? 3 * (k / 2) : 0;
                        pi_s    = pass_s ? k + ng_s : 0;
                        nv_s[k] = grp_s ? (((k % 2) == 0) ? csa_sum(tv_s[b_s], tv_s[b_s+1], tv_s[b_s+2])
                                                          : csa_carry(tv_s[b_s], tv_s[b_s+1], tv_s[b_s+2]))
                                        : (pass_s ? tv_s[pi_s] : {accWidth{1'b0}});
                    end
                    tv_s = nv_s;
                end
                comp_sum_s   = tv_s[0];
                comp_carry_s = tv_s[1];
            end
        end
    endgenerate

    generate
        if (speed == 0) begin : g_ripple
            logic rc_s;

            // Ripple-carry resolve of the redundant pair.
            always_comb begin
                fa_s = {accWidth{1'b0}};
                rc_s = 1'b0;
                for (int i = 0; i < accWidth; i++) begin
                    fa_s[i] = sr_r[i] ^ cr_r[i] ^ rc_s;
                    rc_s    = (sr_r[i] & cr_r[i]) | (rc_s & (sr_r[i] ^ cr_r[i]));
                end
            end
        end else if (speed == 1) begin : g_brent_kung
            logic [accWidth-1:0] pg_s;
            logic [accWidth-1:0] pp_s;
            logic [accWidth-1:0] ng_s;
            logic [accWidth-1:0] np_s;
            logic                sel_s;
            int                  j_s;

            // Brent-Kung prefix: up-sweep on power-of-two spans, then down-sweep fills gaps.
            always_comb begin
                pg_s  = sr_r & cr_r;
                pp_s  = sr_r ^ cr_r;
                ng_s  = pg_s;
                np_s  = pp_s;
                sel_s = 1'b0;
                j_s   = 0;
                for (int l = 0; l < lg; l++) begin
                    for (int i = 0; i < accWidth; i++) begin
                        sel_s   = (((i + 1) % (1 << (l + 1))) == 0);
                        j_s     = sel_s ? i - (1 << l) : i;
                        ng_s[i] = pg_s[i] | (sel_s & pp_s[i] & pg_s[j_s]);
                        np_s[i] = pp_s[i] & (~sel_s | pp_s[j_s]);
                    end
                    pg_s = ng_s;
                    pp_s = np_s;
                end
                for (int l = lg - 2; l >= 0; l--) begin
                    for (int i = 0; i < accWidth; i++) begin
                        sel_s   = (((i + 1) % (1 << (l + 1))) == (1 << l)) && (i >= (1 << (l + 1)));
                        j_s     = sel_s ? i - (1 << l) : i;
                        ng_s[i] = pg_s[i] | (sel_s & pp_s[i] & pg_s[j_s]);
                        np_s[i] = pp_s[i] & (~sel_s | pp_s[j_s]);
                    end
                    pg_s = ng_s;
                    pp_s = np_s;
                end
                fa_s = (sr_r ^ cr_r) ^ (pg_s << 1);
            end
        end else begin : g_sklansky
            logic [accWidth-1:0] pg_s;
            logic [accWidth-1:0] pp_s;
            logic [accWidth-1:0] ng_s;
            logic [accWidth-1:0] np_s;
            logic                sel_s;
            int                  j_s;

            // Sklansky prefix: each level doubles span, nodes fetch from end of lower block.
            always_comb begin
                pg_s  = sr_r & cr_r;
                pp_s  = sr_r ^ cr_r;
                ng_s  = pg_s;
                np_s  = pp_s;
                sel_s = 1'b0;
                j_s   = 0;
                for (int l = 0; l < lg; l++) begin
                    for (int i = 0; i < accWidth; i++) begin
                        sel_s   = (((i >> l) & 1) == 1);
                        j_s     = sel_s ? ((i >> l) << l) - 1 : i;
                        ng_s[i] = pg_s[i] | (sel_s & pp_s[i] & pg_s[j_s]);
                        np_s[i] = pp_s[i] & (~sel_s | pp_s[j_s]);
                    end
                    pg_s = ng_s;
                    pp_s = np_s;
                end
                fa_s = (sr_r ^ cr_r) ^ (pg_s << 1);
            end
        end
    endgenerate

    assign accept_s = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ACC;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ACC:     state_s = (accept_s && in_last) ? RESOLVE : ACC;
            RESOLVE: state_s = OUT;
            OUT:     state_s = out_ready ? ACC : OUT;
            default: state_s = ACC;
        endcase
    end

    // Handshake outputs decoded purely from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            ACC:     in_ready  = 1'b1;
            RESOLVE: in_ready  = 1'b0;
            OUT:     out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Accumulator, beat counter and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_r      <= {accWidth{1'b0}};
            cr_r      <= {accWidth{1'b0}};
            cnt_r     <= {cntWidth{1'b0}};
            out_sum   <= {accWidth{1'b0}};
            out_beats <= {cntWidth{1'b0}};
        end else begin
            case (state_r)
                ACC: begin
                    if (accept_s) begin
                        sr_r  <= comp_sum_s;
                        cr_r  <= comp_carry_s;
                        cnt_r <= (cnt_r == {cntWidth{1'b1}}) ? cnt_r : cnt_r + cntWidth'(1);
                    end
                end
                RESOLVE: begin
                    out_sum   <= fa_s;
                    out_beats <= cnt_r;
                end
                OUT: begin
                    if (out_ready) begin
                        sr_r  <= {accWidth{1'b0}};
                        cr_r  <= {accWidth{1'b0}};
                        cnt_r <= {cntWidth{1'b0}};
                    end
                end
                default: begin
                    sr_r  <= {accWidth{1'b0}};
                    cr_r  <= {accWidth{1'b0}};
                    cnt_r <= {cntWidth{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_mop_seq.sv
// Directed bench for add_mop_seq: four instances (all three speeds at 16/8 bits, plus a
// 12-bit accumulator with a 2-bit counter) share stimulus and are checked against hand values.
module tb_add_mop_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [31:0] in_data;

    logic        rdy0, rdy1, rdy2, rdy3;
    logic        vld0, vld1, vld2, vld3;
    logic [15:0] sum0, sum1, sum2;
    logic [11:0] sum3;
    logic [7:0]  bts0, bts1, bts2;
    logic [1:0]  bts3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    add_mop_seq #(.width(8), .lanes(4), .accWidth(16), .cntWidth(8), .speed(0)) u_d0 (
        .clk_i(clk), .rst_i(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .in_last(in_last), .out_valid(vld0), .out_ready(out_ready), .out_sum(sum0), .out_beats(bts0));
    add_mop_seq #(.width(8), .lanes(4), .accWidth(16), .cntWidth(8), .speed(1)) u_d1 (
        .clk_i(clk), .rst_i(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .in_last(in_last), .out_valid(vld1), .out_ready(out_ready), .out_sum(sum1), .out_beats(bts1));
    add_mop_seq #(.width(8), .lanes(4), .accWidth(16), .cntWidth(8), .speed(2)) u_d2 (
        .clk_i(clk), .rst_i(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .in_last(in_last), .out_valid(vld2), .out_ready(out_ready), .out_sum(sum2), .out_beats(bts2));
    add_mop_seq #(.width(8), .lanes(4), .accWidth(12), .cntWidth(2), .speed(1)) u_d3 (
        .clk_i(clk), .rst_i(rst), .in_valid(in_valid), .in_ready(rdy3), .in_data(in_data),
        .in_last(in_last), .out_valid(vld3), .out_ready(out_ready), .out_sum(sum3), .out_beats(bts3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic rdy, input logic vld);
        chk({tag, "/in_ready0"}, {31'd0, rdy0}, {31'd0, rdy});
        chk({tag, "/in_ready1"}, {31'd0, rdy1}, {31'd0, rdy});
        chk({tag, "/in_ready2"}, {31'd0, rdy2}, {31'd0, rdy});
        chk({tag, "/in_ready3"}, {31'd0, rdy3}, {31'd0, rdy});
        chk({tag, "/out_valid0"}, {31'd0, vld0}, {31'd0, vld});
        chk({tag, "/out_valid1"}, {31'd0, vld1}, {31'd0, vld});
        chk({tag, "/out_valid2"}, {31'd0, vld2}, {31'd0, vld});
        chk({tag, "/out_valid3"}, {31'd0, vld3}, {31'd0, vld});
    endtask

    task automatic check_result(input string tag, input logic [31:0] e16, input logic [31:0] e12,
                                input logic [31:0] eb8, input logic [31:0] eb2);
        chk({tag, "/sum_ripple"},   {16'd0, sum0}, e16);
        chk({tag, "/sum_bk"},       {16'd0, sum1}, e16);
        chk({tag, "/sum_sk"},       {16'd0, sum2}, e16);
        chk({tag, "/sum_acc12"},    {20'd0, sum3}, e12);
        chk({tag, "/beats_ripple"}, {24'd0, bts0}, eb8);
        chk({tag, "/beats_bk"},     {24'd0, bts1}, eb8);
        chk({tag, "/beats_sk"},     {24'd0, bts2}, eb8);
        chk({tag, "/beats_cnt2"},   {30'd0, bts3}, eb2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic last);
        check_ctrl({tag, "/pre_beat"}, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'd0;
    endtask

    // Called right after the last beat: checks the RESOLVE gap, the result, and the handshake.
    task automatic finish_frame(input string tag, input logic [31:0] e16, input logic [31:0] e12,
                                input logic [31:0] eb8, input logic [31:0] eb2);
        check_ctrl({tag, "/resolve"}, 1'b0, 1'b0);
        tick();
        check_ctrl({tag, "/out"}, 1'b0, 1'b1);
        check_result(tag, e16, e12, eb8, eb2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_ctrl({tag, "/after_hs"}, 1'b1, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        #12;
        check_ctrl("reset", 1'b1, 1'b0);
        check_result("reset", 32'd0, 32'd0, 32'd0, 32'd0);
        rst = 1'b0;
        tick();

        // Two-beat frame: 10 + 1020 = 1030.
        beat("two_beat_b0", 32'h04030201, 1'b0);
        beat("two_beat_b1", 32'hFFFFFFFF, 1'b1);
        finish_frame("two_beat", 32'd1030, 32'd1030, 32'd2, 32'd2);

        // Mixed operands: 486 + 455 + 510 = 1451.
        beat("mixed_b0", 32'h256396C8, 1'b0);
        beat("mixed_b1", 32'h4080FA0D, 1'b0);
        beat("mixed_b2", 32'hFE0100FF, 1'b1);
        finish_frame("mixed", 32'd1451, 32'd1451, 32'd3, 32'd3);

        // Wrap: 5 * 1020 = 5100; 5100 mod 4096 = 1004; 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            beat("wrap_beat", 32'hFFFFFFFF, (i == 4) ? 1'b1 : 1'b0);
        end
        finish_frame("wrap", 32'd5100, 32'd1004, 32'd5, 32'd3);

        // Single beat {FF,FF,FF,01}.
        beat("single", 32'h01FFFFFF, 1'b1);
`ifdef ADD_MOP_SEQ_SIGNED_EN
        finish_frame("single_signed", 32'h0000FFFE, 32'h00000FFE, 32'd1, 32'd1);
`else
        finish_frame("single_unsigned", 32'd766, 32'd766, 32'd1, 32'd1);
`endif

        // Backpressure: 0x40+0x30+0x20+0x10 = 160, held while a beat is offered.
        beat("bp_frame", 32'h10203040, 1'b1);
        check_ctrl("bp/resolve", 1'b0, 1'b0);
        tick();
        in_valid = 1'b1;
        in_data  = 32'hFFFFFFFF;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_ctrl("bp/hold", 1'b0, 1'b1);
            check_result("bp/hold", 32'd160, 32'd160, 32'd1, 32'd1);
            tick();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_ctrl("bp/after_hs", 1'b1, 1'b0);
        beat("bp_next", 32'h01010101, 1'b1);
        finish_frame("bp_next", 32'd4, 32'd4, 32'd1, 32'd1);

        // Reset after 3 of 6 beats discards the partial frame and the previous result.
        for (int i = 0; i < 3; i++) begin
            beat("rst_partial", 32'h07070707, 1'b0);
        end
        rst = 1'b1;
        #1;
        check_ctrl("mid_reset", 1'b1, 1'b0);
        check_result("mid_reset", 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        rst = 1'b0;
        check_ctrl("post_reset", 1'b1, 1'b0);
        beat("rst_frame", 32'h02020202, 1'b1);
        finish_frame("rst_frame", 32'd8, 32'd8, 32'd1, 32'd1);

        // Six beats of {10,20,30,40}: 600 exact; 2-bit counter saturates at 3.
        for (int i = 0; i < 6; i++) begin
            beat("sat_beat", 32'h281E140A, (i == 5) ? 1'b1 : 1'b0);
        end
        finish_frame("sat", 32'd600, 32'd600, 32'd6, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
